seg7_reader: RTL
================

SEG7_READER -- requirements
Module: seg7_reader

Interface
REQ-001 SHALL provide parameter: DIGITS, 8, number of digit patterns per frame; legal range 1..8.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: seg_valid  input  1  upstream pattern valid.
REQ-005 SHALL have port: seg_ready  output  1  block accepts pattern.
REQ-006 SHALL have port: seg_in  input  8  pattern, active-low; bit7..bit1 = segments a..g, bit0 = dp.
REQ-007 SHALL have port: word_valid  output  1  decoded frame available.
REQ-008 SHALL have port: word_ready  input  1  downstream accepts frame.
REQ-009 SHALL have port: word_out  output  4*DIGITS  decoded nibbles; first-received digit in the MS nibble.
REQ-010 SHALL have port: dp_mask  output  DIGITS  per-digit dp lit (seg_in[0]==0); first-received digit in the MSB.
REQ-011 SHALL have port: word_err  output  1  at least one unrecognised pattern in the frame.
REQ-012 SHALL have port: err_cnt  output  8  running count of unrecognised patterns (see Configuration).

Function
REQ-013 SHALL decode seg_in[7:1] per fixed table (full-byte values with dp off): 0=0x03, 1=0x9F, 2=0x25, 3=0x0D, 4=0x99, 5=0x49, 6=0x41, 7=0x1F, 8=0x01, 9=0x09, A=0x11, b=0xC1, C=0x63, d=0x85, E=0x61, F=0x71.
REQ-014 SHALL ignore seg_in[0] for table matching.
REQ-015 SHALL decode any unmatched seg_in[7:1] to nibble 0x0 and set the frame error flag.
REQ-016 SHALL implement two states, COLLECT and HOLD; COLLECT is the reset state.
REQ-017 SHALL drive seg_ready=1 in COLLECT and 0 in HOLD.
REQ-018 SHALL count an accept as seg_valid&&seg_ready at a rising edge; on accept, shift the nibble into word_out from the LSB end, shift the dp bit into dp_mask, and increment the digit counter.
REQ-019 SHALL, on the DIGITS-th accept, transition to HOLD and assert word_valid on the following cycle (one-cycle latency from the final accept).
REQ-020 SHALL hold word_out, dp_mask, word_err and word_valid stable in HOLD until word_valid&&word_ready.
REQ-021 SHALL, on the output handshake, return to COLLECT, clear the digit counter and word_err, and deassert word_valid; the next pattern is accepted no earlier than the following cycle.
REQ-022 SHALL keep word_out/dp_mask contents undefined-free; they hold the last shifted values while collecting.
REQ-023 SHALL ignore seg_in while seg_valid=0 and while in HOLD.

Reset
REQ-024 SHALL, with rst=1 at a rising edge, force COLLECT, digit counter 0, word_out 0, dp_mask 0, word_err 0, word_valid 0, err_cnt 0; seg_ready reads 1 from the first cycle after reset.
REQ-025 SHALL give rst priority over any simultaneous accept or handshake; a partial frame is discarded.

Configuration
REQ-026 SHALL compile the error counter only when macro SEG7_READER_ERRCNT_EN is defined.
REQ-027 SHALL, with SEG7_READER_ERRCNT_EN defined, increment err_cnt on each accepted unrecognised pattern, saturating at 0xFF; only rst clears it.
REQ-028 SHALL, without SEG7_READER_ERRCNT_EN, tie err_cnt to 0 with no counter logic.

Verification
REQ-029 SHALL cover DIGITS=8 with the stream 0x25,0x0D,0x99,0x49,0x41,0x1F,0x01,0x09 -> word_out=0x23456789, dp_mask=0x00, word_err=0, word_valid one cycle after the 8th accept.
REQ-030 SHALL cover all 16 patterns with dp lit (e.g. 0x02 -> 0x0) -> correct nibbles and dp_mask bits set.
REQ-031 SHALL cover an invalid pattern 0xFF in digit 3 -> nibble 0x0 at that position, word_err=1, err_cnt+1 (macro on) / err_cnt=0 (macro off).
REQ-032 SHALL cover word_ready held low 5 cycles with seg_valid high -> seg_ready=0, outputs stable; the handshake resumes collecting on the next cycle.
REQ-033 SHALL cover rst after 4 accepts -> all outputs 0; a fresh 8-digit frame decodes correctly.

Source files
------------

// File: rtl/seg7_reader.sv
// seg7_reader: collects DIGITS active-low seven-segment patterns and emits one decoded frame
// Ports: clk/rst (sync, active-high); seg_valid/seg_ready/seg_in pattern input;
//        word_valid/word_ready/word_out/dp_mask/word_err frame output; err_cnt error counter.
// Error counter is built only when SEG7_READER_ERRCNT_EN is defined; otherwise err_cnt is 0.
module seg7_reader #(
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  seg_valid,
  output logic                  seg_ready,
  input  logic [7:0]            seg_in,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic [4*DIGITS-1:0]   word_out,
  output logic [DIGITS-1:0]     dp_mask,
  output logic                  word_err,
  output logic [7:0]            err_cnt
);
  localparam int W = 4 * DIGITS;
  typedef enum logic {COLLECT, HOLD} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [W-1:0] word_q, word_d;
  logic [DIGITS-1:0] dp_q, dp_d;
  logic err_q, err_d;
  logic [3:0] nib;
  logic bad, accept, done;
  assign seg_ready  = state_q == COLLECT;
  assign word_valid = state_q == HOLD;
  assign accept     = seg_valid && seg_ready;
  assign done       = word_valid && word_ready;
  assign word_out   = word_q;
  assign dp_mask    = dp_q;
  assign word_err   = err_q;
  // dp bit forced high so the table matches on segments a..g only
  always_comb begin
    nib = 4'h0;
    bad = 1'b0;
    case ({seg_in[7:1], 1'b1})
      8'h03: nib = 4'h0;
      8'h9F: nib = 4'h1;
      8'h25: nib = 4'h2;
      8'h0D: nib = 4'h3;
      8'h99: nib = 4'h4;
      8'h49: nib = 4'h5;
      8'h41: nib = 4'h6;
      8'h1F: nib = 4'h7;
      8'h01: nib = 4'h8;
      8'h09: nib = 4'h9;
      8'h11: nib = 4'hA;
      8'hC1: nib = 4'hB;
      8'h63: nib = 4'hC;
      8'h85: nib = 4'hD;
      8'h61: nib = 4'hE;
      8'h71: nib = 4'hF;
      default: bad = 1'b1;
    endcase
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    dp_d    = dp_q;
    err_d   = err_q;
    if (accept) begin
      word_d  = W'({word_q, nib});
      dp_d    = DIGITS'({dp_q, ~seg_in[0]});
      err_d   = err_q | bad;
      cnt_d   = cnt_q + 4'd1;
      state_d = (cnt_q == 4'(DIGITS - 1)) ? HOLD : COLLECT;
    end
    if (done) begin
      state_d = COLLECT;
      cnt_d   = 4'd0;
      err_d   = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      cnt_q   <= 4'd0;
      word_q  <= '0;
      dp_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      dp_q    <= dp_d;
      err_q   <= err_d;
    end
  end
`ifdef SEG7_READER_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;
  always_comb err_cnt_d = (accept && bad && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  always_ff @(posedge clk) begin
    err_cnt_q <= rst ? 8'h00 : err_cnt_d;
  end
  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'h00;
`endif
endmodule
